memories_param: RTL and testbench
=================================

// Module: memories_param
// PURPOSE
//  Parametrised successor of the single-config byte-select RAM: one read port, one write port, configurable width/depth.
//  Adds read latency pipeline, out-of-range error flags, defined read-during-write and an optional forwarding path.
//  Sits beside the core datapath as scratch/register storage; memory is inferred as an array of DATA_W-bit words.
// PARAMETERS
//  DATA_W   32   data width in bits; multiple of 8, 8..64
//  ADDR_W   32   address port width in bits
//  DEPTH    256  number of words; 2..2^16, need not be a power of two
//  RD_LAT   1    read latency in cycles, 1..4
// PORTS
//  clk       in   1         clock, all state on rising edge
//  arst      in   1         asynchronous reset, active-high
//  rd_addr   in   ADDR_W    word address for read
//  rd_en     in   1         read request, sampled each edge
//  wr_addr   in   ADDR_W    word address for write
//  wr_data   in   DATA_W    write data
//  wr_bsel   in   DATA_W/8  byte enables; bit i -> wr_data[8i+7:8i]
//  wr_en     in   1         write request, sampled each edge
//  rd_data   out  DATA_W    read data, valid when rd_valid=1, else 0
//  rd_valid  out  1         one-cycle pulse per accepted read
//  rd_err    out  1         qualifies rd_valid: read address out of range
//  wr_ack    out  1         one-cycle pulse per accepted write
//  wr_err    out  1         qualifies wr_ack: write address out of range
// BEHAVIOUR
//  - Reset: arst clears rd_data, rd_valid, rd_err, wr_ack, wr_err and all read pipeline stages to 0 immediately.
//    Memory array is NOT cleared; contents after power-up undefined, preserved across arst.
//  - Reset mid-read: in-flight reads discarded; no rd_valid for them after arst deasserts.
//  - No backpressure: one read and one write accepted every cycle, independent of each other.
//  - Range: address in range iff addr < DEPTH (full ADDR_W compare, no truncation/wrap).
//  - Write: edge with wr_en=1 and in range updates only bytes with wr_bsel[i]=1; wr_bsel=0 leaves word unchanged.
//    Out-of-range write leaves the array unchanged.
//  - wr_ack=1 in the cycle after every wr_en edge (including bsel=0); wr_err=1 alongside it iff out of range.
//  - Read: array sampled at issue edge k; rd_valid=1 exactly in cycle after edge k+RD_LAT-1 (RD_LAT=1: next cycle).
//    Out-of-range read: rd_data=0, rd_err=1 with rd_valid. Back-to-back reads give back-to-back rd_valid, in order.
//  - Writes after issue edge k never change that read's data (data captured at issue).
//  - Read-during-write, same in-range address, same edge: read-first (returns old word) unless forwarding enabled.
//  - rd_data forced 0 whenever rd_valid=0.
//  - Elaboration error if DATA_W%8!=0, RD_LAT outside 1..4, DEPTH<2 or DEPTH>2^ADDR_W.
// CONFIGURATION
//  MEMORIES_PARAM_WR_FORWARD_EN
//   defined:   same-edge same-address read returns merged word: bytes with wr_bsel=1 from wr_data, rest old.
//              Out-of-range writes never forward.
//   undefined: read-first as above; no bypass mux synthesised.
// TESTING
//  1 arst pulse mid-stream, RD_LAT=3, reads in flight -> all outputs 0 at once; no rd_valid for discarded reads.
//  2 write addr 5 data 0xDEADBEEF bsel 0xF, then bsel 0x2 data 0x00001100 -> wr_ack each; read 5 -> 0xDEAD11EF.
//  3 DEPTH=200: write addr 200 -> wr_ack=1, wr_err=1, no change; read addr 200 -> rd_valid=1, rd_err=1, rd_data=0.
//  4 RD_LAT=1..4, reads of addrs 0..7 back-to-back -> rd_valid 8 consecutive cycles, starting RD_LAT cycles after first issue, in order.
//  5 word 9=0x11223344; same-edge read 9 + write 9 data 0xAABBCCDD bsel 0x5
//    -> 0x11223344 without macro, 0x11BB33DD with MEMORIES_PARAM_WR_FORWARD_EN.
//  6 1000 cycles random rd/wr, addrs 0..DEPTH+15, against behavioural model -> zero mismatches, both macro settings.

Source files
------------

// File: rtl/memories_param.sv
// Parametrised 1R/1W word RAM with byte-enable writes, RD_LAT-deep read pipeline and range flags.
// Optional same-edge write-to-read forwarding is enabled by defining MEMORIES_PARAM_WR_FORWARD_EN.

module memories_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_bsel,
  input  logic                wr_en,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_err,
  output logic                wr_ack,
  output logic                wr_err
);

  // Handshake: there is no ready. Every edge with rd_en/wr_en=1 is accepted; rd_valid and
  // wr_ack are one-cycle pulses (one per accepted request, in order), and rd_err/wr_err are
  // meaningful only while their pulse is high.

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
    $error("memories_param: DATA_W must be a multiple of 8 in 8..64");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("memories_param: RD_LAT must be in 1..4");
  end
  if (DEPTH < 2 || DEPTH > 65536 || (ADDR_W < 17 && DEPTH > (1 << ADDR_W))) begin : g_bad_depth
    $error("memories_param: DEPTH must be in 2..min(2^16, 2^ADDR_W)");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_in_range;
  logic              wr_in_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] rd_word;

  // Full-width compare so an address like DEPTH+2^IDX_W never aliases onto a real word.
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_X;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign old_word    = mem[rd_idx];

`ifdef MEMORIES_PARAM_WR_FORWARD_EN
  always_comb begin
    rd_word = old_word;
    if (wr_en && wr_in_range && (rd_addr == wr_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_bsel[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end
`else
  assign rd_word = old_word;
`endif

  // Array is deliberately outside the reset domain: contents survive arst.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_bsel[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_err;
  logic [DATA_W-1:0] pipe_data [RD_LAT];

  // Stage 0 captures the word at the issue edge; later stages only delay it.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= rd_en;
      pipe_err[0]   <= rd_en && !rd_in_range;
      pipe_data[0]  <= (rd_en && rd_in_range) ? rd_word : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_en;
      wr_err <= wr_en && !wr_in_range;
    end
  end

  assign rd_valid = pipe_valid[RD_LAT-1];
  assign rd_err   = pipe_err[RD_LAT-1];
  assign rd_data  = pipe_valid[RD_LAT-1] ? pipe_data[RD_LAT-1] : '0;

endmodule

// File: tb/tb_memories_param.sv
// Bench for memories_param: four instances (RD_LAT=1..4, DEPTH=200, ADDR_W=16) share one stimulus
// stream; a reference memory model feeds an expected queue consumed per instance at its latency.

module tb_memories_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 200;
  localparam int NL     = 4;
  localparam int EW     = 65;  // {issue step[31:0], err, data[31:0]}
`ifdef MEMORIES_PARAM_WR_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [31:0] T5_EXP = FWD ? 32'h11BB33DD : 32'h11223344;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arst;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_bsel;
  logic              wr_en;

  logic [DATA_W-1:0] rd_data_w  [NL];
  logic              rd_valid_w [NL];
  logic              rd_err_w   [NL];
  logic              wr_ack_w   [NL];
  logic              wr_err_w   [NL];

  for (genvar g = 0; g < NL; g++) begin : g_dut
    memories_param #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(g + 1)
    ) u_dut (
      .clk      (clk),
      .arst     (arst),
      .rd_addr  (rd_addr),
      .rd_en    (rd_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_bsel  (wr_bsel),
      .wr_en    (wr_en),
      .rd_data  (rd_data_w[g]),
      .rd_valid (rd_valid_w[g]),
      .rd_err   (rd_err_w[g]),
      .wr_ack   (wr_ack_w[g]),
      .wr_err   (wr_err_w[g])
    );
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]     exp_q [$];
  int                hd [NL];
  logic [DATA_W-1:0] mdl [DEPTH];
  logic              exp_ack;
  logic              exp_werr;
  int                stp;
  int                n_cmp;
  int                n_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d)", tag, obs, exp, stp);
    end
  endtask

  task automatic check_outputs();
    logic due;
    for (int l = 0; l < NL; l++) begin
      due = (hd[l] < exp_q.size()) && ((int'(exp_q[hd[l]][64:33]) + l + 1) == stp);
      check($sformatf("lane%0d rd_valid", l), 64'(rd_valid_w[l]), 64'(due));
      if (due) begin
        check($sformatf("lane%0d rd_data", l), 64'(rd_data_w[l]), 64'(exp_q[hd[l]][31:0]));
        check($sformatf("lane%0d rd_err", l), 64'(rd_err_w[l]), 64'(exp_q[hd[l]][32]));
        hd[l]++;
      end else begin
        check($sformatf("lane%0d rd_data idle", l), 64'(rd_data_w[l]), 64'd0);
        check($sformatf("lane%0d rd_err idle", l), 64'(rd_err_w[l]), 64'd0);
      end
      check($sformatf("lane%0d wr_ack", l), 64'(wr_ack_w[l]), 64'(exp_ack));
      check($sformatf("lane%0d wr_err", l), 64'(wr_err_w[l]), 64'(exp_werr));
    end
    while (hd[NL-1] > 0) begin
      void'(exp_q.pop_front());
      for (int l = 0; l < NL; l++) hd[l]--;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic re, input logic [ADDR_W-1:0] ra,
                      input logic we, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd, input logic [3:0] bs,
                      input bit fx, input logic [DATA_W-1:0] fv);
    logic [DATA_W-1:0] d;
    logic              e;
    @(negedge clk);
    check_outputs();
    rd_en   = re;
    rd_addr = ra;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_bsel = bs;
    if (re) begin
      if (ra < DEPTH) begin
        d = mdl[ra[7:0]];
        e = 1'b0;
        if (FWD && we && (wa < DEPTH) && (wa == ra)) begin
          for (int b = 0; b < 4; b++) if (bs[b]) d[8*b +: 8] = wd[8*b +: 8];
        end
      end else begin
        d = '0;
        e = 1'b1;
      end
      if (fx) d = fv;
      exp_q.push_back({32'(stp), e, d});
    end
    if (we && (wa < DEPTH)) begin
      for (int b = 0; b < 4; b++) if (bs[b]) mdl[wa[7:0]][8*b +: 8] = wd[8*b +: 8];
    end
    exp_ack  = we;
    exp_werr = we && (wa >= DEPTH);
    stp++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b0, '0);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input bit fx, input logic [DATA_W-1:0] fv);
    step(1'b1, a, 1'b0, '0, '0, 4'h0, fx, fv);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [3:0] bs);
    step(1'b0, '0, 1'b1, a, d, bs, 1'b0, '0);
  endtask

  // Asynchronous pulse between edges while reads are still in flight.
  task automatic reset_pulse();
    #2 arst = 1'b1;
    #1;
    for (int l = 0; l < NL; l++) begin
      check($sformatf("arst lane%0d rd_valid", l), 64'(rd_valid_w[l]), 64'd0);
      check($sformatf("arst lane%0d rd_data", l), 64'(rd_data_w[l]), 64'd0);
      check($sformatf("arst lane%0d rd_err", l), 64'(rd_err_w[l]), 64'd0);
      check($sformatf("arst lane%0d wr_ack", l), 64'(wr_ack_w[l]), 64'd0);
      check($sformatf("arst lane%0d wr_err", l), 64'(wr_err_w[l]), 64'd0);
      hd[l] = 0;
    end
    exp_q.delete();
    exp_ack  = 1'b0;
    exp_werr = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    @(negedge clk);
    #1 arst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] wa;
    n_cmp    = 0;
    n_bad    = 0;
    stp      = 0;
    exp_ack  = 1'b0;
    exp_werr = 1'b0;
    for (int l = 0; l < NL; l++) hd[l] = 0;
    arst    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_bsel = '0;

    #1 arst = 1'b1;
    #1;
    for (int l = 0; l < NL; l++) begin
      check($sformatf("reset lane%0d rd_valid", l), 64'(rd_valid_w[l]), 64'd0);
      check($sformatf("reset lane%0d rd_data", l), 64'(rd_data_w[l]), 64'd0);
      check($sformatf("reset lane%0d wr_ack", l), 64'(wr_ack_w[l]), 64'd0);
    end
    @(negedge clk);
    #1 arst = 1'b0;

    // Give every word a known value so later reads have defined expectations.
    for (int a = 0; a < DEPTH; a++) wr(ADDR_W'(a), $urandom, 4'hF);

    // Byte-select merge.
    wr(16'd5, 32'hDEADBEEF, 4'hF);
    wr(16'd5, 32'h00001100, 4'h2);
    wr(16'd6, 32'h12345678, 4'h0);
    rd(16'd5, 1'b1, 32'hDEAD11EF);
    idle(5);

    // Range boundary, including an address that would alias if truncated.
    wr(16'd200, 32'hFFFFFFFF, 4'hF);
    wr(16'd261, 32'hFFFFFFFF, 4'hF);
    rd(16'd200, 1'b1, 32'h0);
    rd(16'd199, 1'b0, '0);
    rd(16'd261, 1'b1, 32'h0);
    rd(16'hFFFF, 1'b1, 32'h0);
    rd(16'd5, 1'b1, 32'hDEAD11EF);
    idle(5);

    // Same-edge read/write to one address.
    wr(16'd9, 32'h11223344, 4'hF);
    step(1'b1, 16'd9, 1'b1, 16'd9, 32'hAABBCCDD, 4'h5, 1'b1, T5_EXP);
    rd(16'd9, 1'b1, 32'h11BB33DD);
    idle(5);

    // Back-to-back burst: latency and ordering per lane.
    for (int a = 0; a < 8; a++) rd(ADDR_W'(a), 1'b0, '0);
    idle(6);

    // Reset with reads in flight; array contents must survive.
    for (int a = 0; a < 6; a++) rd(ADDR_W'(a + 10), 1'b0, '0);
    reset_pulse();
    idle(2);
    rd(16'd5, 1'b1, 32'hDEAD11EF);
    idle(5);

    // Random traffic against the model.
    for (int i = 0; i < 1000; i++) begin
      ra = ADDR_W'($urandom_range(0, DEPTH + 15));
      wa = ($urandom_range(0, 3) == 0) ? ra : ADDR_W'($urandom_range(0, DEPTH + 15));
      step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom,
           4'($urandom_range(0, 15)), 1'b0, '0);
    end
    idle(8);
    check("drain queue empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
